// File: rtl/bcd_debounce_counter.sv
// Pushbutton front end: 2-FF sync, debounce, press detect and 4-digit packed-BCD counter.
// Define COUNT_DOWN_EN to add the btn_down input and BCD decrement with borrow.
module bcd_debounce_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_clr,
`ifdef COUNT_DOWN_EN
    input  logic        btn_down,
`endif
    output logic [15:0] counted,
    output logic        wrap,
    output logic        up_level
);

    localparam int unsigned BtnUp  = 0;
    localparam int unsigned BtnClr = 1;
`ifdef COUNT_DOWN_EN
    localparam int unsigned BtnDown = 2;
    localparam int unsigned NumBtn  = 3;
`else
    localparam int unsigned NumBtn  = 2;
`endif

    // Terminal count: the level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdleLow,
        StConfirmHigh,
        StIdleHigh,
        StConfirmLow
    } db_state_e;

    logic [NumBtn-1:0] btn_raw;
    logic [NumBtn-1:0] sync1_q;
    logic [NumBtn-1:0] sync2_q;
    db_state_e         db_state_q [NumBtn];
    logic [CNT_W-1:0]  db_cnt_q   [NumBtn];
    logic [NumBtn-1:0] stable;
    logic [NumBtn-1:0] hist_q;
    logic [NumBtn-1:0] press_q;
    logic [15:0]       counted_q;
    logic              wrap_q;
    logic              up_evt;
    logic              down_evt;

    always_comb begin
        btn_raw         = '0;
        btn_raw[BtnUp]  = btn_up;
        btn_raw[BtnClr] = btn_clr;
`ifdef COUNT_DOWN_EN
        btn_raw[BtnDown] = btn_down;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-button debounce FSM; abandoning a confirm returns to the prior idle level.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NumBtn; i++) begin
            if (reset) begin
                db_state_q[i] <= StIdleLow;
                db_cnt_q[i]   <= '0;
            end else begin
                unique case (db_state_q[i])
                    StIdleLow: begin
                        if (sync2_q[i]) begin
                            db_state_q[i] <= StConfirmHigh;
                            db_cnt_q[i]   <= CNT_W'(1);
                        end else begin
                            db_cnt_q[i]   <= '0;
                        end
                    end
                    StConfirmHigh: begin
                        if (!sync2_q[i]) begin
                            db_state_q[i] <= StIdleLow;
                            db_cnt_q[i]   <= '0;
                        end else if (db_cnt_q[i] == CntLast) begin
                            db_state_q[i] <= StIdleHigh;
                            db_cnt_q[i]   <= '0;
                        end else begin
                            db_cnt_q[i]   <= db_cnt_q[i] + CNT_W'(1);
                        end
                    end
                    StIdleHigh: begin
                        if (!sync2_q[i]) begin
                            db_state_q[i] <= StConfirmLow;
                            db_cnt_q[i]   <= CNT_W'(1);
                        end else begin
                            db_cnt_q[i]   <= '0;
                        end
                    end
                    StConfirmLow: begin
                        if (sync2_q[i]) begin
                            db_state_q[i] <= StIdleHigh;
                            db_cnt_q[i]   <= '0;
                        end else if (db_cnt_q[i] == CntLast) begin
                            db_state_q[i] <= StIdleLow;
                            db_cnt_q[i]   <= '0;
                        end else begin
                            db_cnt_q[i]   <= db_cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        db_state_q[i] <= StIdleLow;
                        db_cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        stable = '0;
        for (int i = 0; i < NumBtn; i++) begin
            stable[i] = (db_state_q[i] == StIdleHigh) || (db_state_q[i] == StConfirmLow);
        end
    end

    // Rising edge of the debounced level only; releases are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q  <= '0;
            press_q <= '0;
        end else begin
            hist_q  <= stable;
            press_q <= stable & ~hist_q;
        end
    end

    function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic down);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (!down) begin
                    if (v[4*d +: 4] == 4'd9) begin
                        r[4*d +: 4] = 4'd0;
                    end else begin
                        r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    if (v[4*d +: 4] == 4'd0) begin
                        r[4*d +: 4] = 4'd9;
                    end else begin
                        r[4*d +: 4] = v[4*d +: 4] - 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

`ifdef COUNT_DOWN_EN
    assign up_evt   = press_q[BtnUp] & ~press_q[BtnDown];
    assign down_evt = press_q[BtnDown] & ~press_q[BtnUp];
`else
    assign up_evt   = press_q[BtnUp];
    assign down_evt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            counted_q <= 16'h0000;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (press_q[BtnClr]) begin
                counted_q <= 16'h0000;
            end else if (up_evt) begin
                counted_q <= bcd_step(counted_q, 1'b0);
                wrap_q    <= (counted_q == 16'h9999);
            end else if (down_evt) begin
                counted_q <= bcd_step(counted_q, 1'b1);
                wrap_q    <= (counted_q == 16'h0000);
            end
        end
    end

    assign counted  = counted_q;
    assign wrap     = wrap_q;
    assign up_level = stable[BtnUp];

endmodule

// File: tb/tb_bcd_debounce_counter.sv
// Randomized bench for bcd_debounce_counter against a window-based debounce model
// and an integer event counter; define COUNT_DOWN_EN to also exercise btn_down.
module tb_bcd_debounce_counter;

    localparam int unsigned D = 4;
`ifdef COUNT_DOWN_EN
    localparam bit DownEn = 1'b1;
`else
    localparam bit DownEn = 1'b0;
`endif
    localparam logic [31:0] DMask = (32'd1 << D) - 32'd1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_clr = 1'b0;
    logic        btn_down = 1'b0;
    logic [15:0] counted;
    logic        wrap;
    logic        up_level;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: event count as an integer, per-button sync chain and sample history.
    int          n = 0;
    logic        m_wrap = 1'b0;
    logic [2:0]  m_s1 = '0;
    logic [2:0]  m_s2 = '0;
    logic [2:0]  m_stable = '0;
    logic [2:0]  m_rose = '0;
    logic [2:0]  m_press = '0;
    logic [31:0] shist [3];
    int          nvalid [3];

    bcd_debounce_counter #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_up  (btn_up),
        .btn_clr (btn_clr),
`ifdef COUNT_DOWN_EN
        .btn_down(btn_down),
`endif
        .counted (counted),
        .wrap    (wrap),
        .up_level(up_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic model_reset();
        n = 0;
        m_wrap = 1'b0;
        m_s1 = '0;
        m_s2 = '0;
        m_stable = '0;
        m_rose = '0;
        m_press = '0;
        for (int b = 0; b < 3; b++) begin
            shist[b]  = '0;
            nvalid[b] = 0;
        end
    endtask

    // One clock edge of the reference, using the inputs the DUT sampled at that edge.
    task automatic model_step();
        logic [2:0] raw;
        logic       up_ev;
        logic       dn_ev;
        raw = {btn_down, btn_clr, btn_up};
        if (reset) begin
            model_reset();
            return;
        end
        m_wrap = 1'b0;
        up_ev = m_press[0] && !(DownEn && m_press[2]);
        dn_ev = DownEn && m_press[2] && !m_press[0];
        if (m_press[1]) begin
            n = 0;
        end else if (up_ev) begin
            if (n == 9999) begin n = 0; m_wrap = 1'b1; end
            else n = n + 1;
        end else if (dn_ev) begin
            if (n == 0) begin n = 9999; m_wrap = 1'b1; end
            else n = n - 1;
        end
        for (int b = 0; b < 3; b++) begin
            m_press[b] = m_rose[b];
            m_rose[b]  = 1'b0;
            shist[b]   = {shist[b][30:0], m_s2[b]};
            if (nvalid[b] < 32) nvalid[b]++;
            // The level flips once the last D samples all disagree with it.
            if (nvalid[b] >= int'(D) &&
                (shist[b] & DMask) == (m_stable[b] ? 32'd0 : DMask)) begin
                m_rose[b]   = !m_stable[b];
                m_stable[b] = !m_stable[b];
                nvalid[b]   = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("counted", counted, to_bcd(n));
        check("wrap", {15'd0, wrap}, {15'd0, m_wrap});
        check("up_level", {15'd0, up_level}, {15'd0, m_stable[0]});
    endtask

    task automatic idle(input int c);
        repeat (c) tick();
    endtask

    task automatic set_btns(input logic [2:0] mask);
        btn_up   = mask[0];
        btn_clr  = mask[1];
        btn_down = DownEn ? mask[2] : 1'b0;
    endtask

    task automatic press(input logic [2:0] mask, input int h, input int l);
        set_btns(mask);
        repeat (h) tick();
        set_btns(3'b000);
        repeat (l) tick();
    endtask

    task automatic do_reset(input int c);
        reset = 1'b1;
        repeat (c) tick();
        reset = 1'b0;
    endtask

    task automatic preload(input logic [15:0] bcd, input int val);
        force dut.counted_q = bcd;
        #1;
        release dut.counted_q;
        n = val;
    endtask

    initial begin
        model_reset();
        do_reset(3);
        check("reset_counted", counted, 16'h0000);
        check("reset_level", {15'd0, up_level}, 16'd0);

        // Held button: level rises D+2 edges after the raw edge, one count only.
        btn_up = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 5) check("lat_pre", {15'd0, up_level}, 16'd0);
            if (k == 6) check("lat_up", {15'd0, up_level}, 16'd1);
        end
        check("held_once", counted, 16'h0001);
        btn_up = 1'b0;
        idle(10);

        // Bounce shorter than D never changes the level.
        do_reset(2);
        for (int k = 0; k < 12; k++) begin
            btn_up = 1'b1;
            tick();
            btn_up = 1'b0;
            idle(2);
        end
        for (int k = 0; k < 20; k++) begin
            btn_up = ~btn_up;
            idle($urandom_range(1, D - 1));
        end
        btn_up = 1'b0;
        idle(8);
        check("bounce_cnt", counted, 16'h0000);

        // Count to 42, clear, then clear coincident with up.
        for (int k = 0; k < 42; k++) press(3'b001, $urandom_range(D, 9), $urandom_range(D, 9));
        idle(6);
        check("cnt42", counted, 16'h0042);
        press(3'b010, 6, 8);
        check("clr", counted, 16'h0000);
        press(3'b001, 6, 8);
        press(3'b011, 6, 8);
        check("clr_up", counted, 16'h0000);

        // Through 0009->0010 and 0099->0100.
        for (int k = 0; k < 105; k++) press(3'b001, $urandom_range(D, 8), $urandom_range(D, 8));
        idle(6);
        check("cnt105", counted, 16'h0105);

        // Reset in the middle of confirming a held button.
        do_reset(2);
        btn_up = 1'b1;
        idle(4);
        do_reset(2);
        btn_up = 1'b1;
        idle(5);
        check("reconf_wait", counted, 16'h0000);
        idle(10);
        check("reconf_one", counted, 16'h0001);
        btn_up = 1'b0;
        idle(10);

        // Wrap 9999 -> 0000.
        preload(16'h9990, 9990);
        for (int k = 0; k < 10; k++) press(3'b001, $urandom_range(D, 7), $urandom_range(D, 7));
        idle(6);
        check("wrap_zero", counted, 16'h0000);

        if (DownEn) begin
            do_reset(2);
            press(3'b100, 6, 10);
            check("down_wrap", counted, 16'h9999);
            idle(4);
            preload(16'h0100, 100);
            press(3'b100, 6, 10);
            check("down_borrow", counted, 16'h0099);
            press(3'b101, 6, 10);
            check("up_down", counted, 16'h0099);
        end

        // Free-running random buttons with occasional reset.
        do_reset(2);
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 40) == 0) btn_clr = ~btn_clr;
            if (DownEn && $urandom_range(0, 7) == 0) btn_down = ~btn_down;
            reset = ($urandom_range(0, 400) == 0);
            tick();
        end
        reset = 1'b0;
        set_btns(3'b000);
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
